c_drain_io_l3_out_serialize_c_m_axi_read_arb: RTL
=================================================

C_DRAIN_IO_L3_OUT_SERIALIZE_C_M_AXI_READ_ARB -- requirements
Module: C_drain_IO_L3_out_serialize_C_m_axi_read_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of HLS read requesters (2..4).
REQ-002 SHALL have parameter BUS_ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter BUS_DATA_WIDTH, default 32, read data width.
REQ-004 SHALL have parameter NUM_READ_OUTSTANDING, default 2, order-FIFO depth (power of 2).
REQ-005 SHALL have ports: ACLK  in  1  clock; ARESET  in  1  reset, synchronous, active-high; ACLK_EN  in  1  clock enable.
REQ-006 SHALL have requester side: in_P_ARADDR  in  NUM_PORTS*BUS_ADDR_WIDTH  packed addresses; in_P_ARLEN  in  NUM_PORTS*32  packed lengths; in_P_ARVALID  in  NUM_PORTS; out_P_ARREADY  out  NUM_PORTS.
REQ-007 SHALL have requester return: out_P_RDATA  out  BUS_DATA_WIDTH  broadcast data; out_P_RLAST  out  2  broadcast {burst_end, request_end}; out_P_RVALID  out  NUM_PORTS; in_P_RREADY  in  NUM_PORTS; in_P_RBURST_READY  in  NUM_PORTS.
REQ-008 SHALL have shared read-port side: out_HLS_ARADDR  out  BUS_ADDR_WIDTH; out_HLS_ARLEN  out  32; out_HLS_ARVALID  out  1; in_HLS_ARREADY  in  1; in_HLS_RDATA  in  BUS_DATA_WIDTH; in_HLS_RLAST  in  2; in_HLS_RVALID  in  1; out_HLS_RREADY  out  1; out_HLS_RBUST_READY  out  1.

Function
REQ-009 SHALL run a two-state request FSM: IDLE (holding register empty), BUSY (holding register full).
REQ-010 IDLE: if any in_P_ARVALID and order FIFO not full, SHALL select one winner, assert out_P_ARREADY[winner] for that cycle only, capture ARADDR/ARLEN/port index, push index into order FIFO, go BUSY.
REQ-011 IDLE with order FIFO full SHALL assert no out_P_ARREADY and stay IDLE.
REQ-012 BUSY: out_HLS_ARVALID=1 with captured ADDR/LEN held stable; on in_HLS_ARREADY SHALL return to IDLE; no new capture in that cycle (max 1 request per 2 cycles).
REQ-013 Default arbitration SHALL be round-robin: search starts at (last winner + 1) mod NUM_PORTS; last-winner pointer updates only on capture.
REQ-014 Return routing SHALL use order-FIFO head h: out_P_RVALID[h]=in_HLS_RVALID, others 0; out_HLS_RREADY=in_P_RREADY[h]; out_HLS_RBUST_READY=in_P_RBURST_READY[h].
REQ-015 Order FIFO empty SHALL force out_P_RVALID=0, out_HLS_RREADY=0, out_HLS_RBUST_READY=0.
REQ-016 Pop SHALL occur on in_HLS_RVALID && out_HLS_RREADY && in_HLS_RLAST[0]; simultaneous push and pop SHALL keep count unchanged and be legal when full.
REQ-017 out_P_RDATA and out_P_RLAST SHALL be combinational pass-through of in_HLS_RDATA/in_HLS_RLAST (zero latency).
REQ-018 All state updates (FSM, pointer, FIFO) SHALL occur only when ACLK_EN=1; outputs derive from current state.

Reset
REQ-019 ARESET=1 at a rising ACLK (regardless of ACLK_EN) SHALL force IDLE, round-robin pointer to NUM_PORTS-1 (port 0 first), order FIFO empty, holding register 0.
REQ-020 After reset: out_HLS_ARVALID=0, out_P_ARREADY=0, out_P_RVALID=0, out_HLS_RREADY=0, out_HLS_RBUST_READY=0; reset mid-BUSY SHALL drop the pending request without handshake.

Configuration
REQ-021 With macro CDRAIN_READ_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins, pointer unused); without it, round-robin per REQ-013.

Structure
REQ-022 Shared package SHALL hold FSM state enum (IDLE, BUSY) and port-index width constant log2(NUM_PORTS).
REQ-023 Order FIFO SHALL be a separate sub-module C_drain_IO_L3_out_serialize_C_m_axi_read_arb_ofifo (depth NUM_READ_OUTSTANDING, width log2(NUM_PORTS)).

Verification
REQ-024 Port0 and port1 both request ARADDR 0x100/0x200 at reset release -> port0 granted first, port1 next; out_HLS_ARADDR 0x100 then 0x200.
REQ-025 Both ports request continuously, in_HLS_ARREADY=1 -> grants alternate 0,1,0,1 one every 2 cycles (fixed-priority build: 0,0,0).
REQ-026 Two requests granted, third pending, no R data -> FIFO full, third not granted until RLAST[0] beat of first request pops.
REQ-027 Data 0xA,0xB (RLAST=2'b10, 2'b11) for port1 head -> only out_P_RVALID[1] high; pop on 0xB; next beat routed to new head.
REQ-028 in_HLS_ARREADY=0 for 5 cycles in BUSY -> out_HLS_ARADDR/ARLEN stable, out_P_ARREADY all 0.
REQ-029 ARESET asserted in BUSY with FIFO holding 2 entries -> next cycle out_HLS_ARVALID=0, out_HLS_RREADY=0, port0 wins next request.

Source files
------------

// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_read_arb_pkg.sv
// Shared types and sizing helpers for the HLS m_axi read arbiter.
package c_drain_io_l3_out_serialize_c_m_axi_read_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Port-index width; a single requester still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_IDX_W     = idx_w(DEF_NUM_PORTS);

endpackage

// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_read_arb_ofifo.sv
// Order FIFO: remembers which requester owns each outstanding read burst.
module c_drain_io_l3_out_serialize_c_m_axi_read_arb_ofifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign dout    = mem[rp];
  // A pop frees the slot being written, so push-while-full is legal then.
  assign do_push = en && push && (!full || pop);
  assign do_pop  = en && pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_read_arb.sv
// N-to-1 read arbiter in front of a shared HLS m_axi read port; R beats are
// routed back in request order. Define CDRAIN_READ_ARB_FIXED_PRIO_EN for
// fixed lowest-index-wins arbitration instead of round-robin.
module c_drain_io_l3_out_serialize_c_m_axi_read_arb
  import c_drain_io_l3_out_serialize_c_m_axi_read_arb_pkg::*;
#(
  parameter int NUM_PORTS            = 2,
  parameter int BUS_ADDR_WIDTH       = 32,
  parameter int BUS_DATA_WIDTH       = 32,
  parameter int NUM_READ_OUTSTANDING = 2
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic                                ACLK_EN,
  input  logic [NUM_PORTS*BUS_ADDR_WIDTH-1:0] in_P_ARADDR,
  input  logic [NUM_PORTS*32-1:0]             in_P_ARLEN,
  input  logic [NUM_PORTS-1:0]                in_P_ARVALID,
  output logic [NUM_PORTS-1:0]                out_P_ARREADY,
  output logic [BUS_DATA_WIDTH-1:0]           out_P_RDATA,
  output logic [1:0]                          out_P_RLAST,
  output logic [NUM_PORTS-1:0]                out_P_RVALID,
  input  logic [NUM_PORTS-1:0]                in_P_RREADY,
  input  logic [NUM_PORTS-1:0]                in_P_RBURST_READY,
  output logic [BUS_ADDR_WIDTH-1:0]           out_HLS_ARADDR,
  output logic [31:0]                         out_HLS_ARLEN,
  output logic                                out_HLS_ARVALID,
  input  logic                                in_HLS_ARREADY,
  input  logic [BUS_DATA_WIDTH-1:0]           in_HLS_RDATA,
  input  logic [1:0]                          in_HLS_RLAST,
  input  logic                                in_HLS_RVALID,
  output logic                                out_HLS_RREADY,
  output logic                                out_HLS_RBUST_READY
);

  localparam int IW = idx_w(NUM_PORTS);

  arb_state_e                state;
  logic [BUS_ADDR_WIDTH-1:0] hold_addr;
  logic [31:0]               hold_len;
  logic [IW-1:0]             win, head;
  logic                      any_req, grant, pop, f_empty, f_full;
`ifndef CDRAIN_READ_ARB_FIXED_PRIO_EN
  logic [IW-1:0]             rr_ptr;
`endif

  // Descending scan so the highest-priority candidate is assigned last.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
`ifdef CDRAIN_READ_ARB_FIXED_PRIO_EN
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if (in_P_ARVALID[i]) begin
        win     = IW'(i);
        any_req = 1'b1;
      end
    end
`else
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (in_P_ARVALID[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        win     = IW'((int'(rr_ptr) + i) % NUM_PORTS);
        any_req = 1'b1;
      end
    end
`endif
  end

  // Grant is withheld while the clock enable is low so no handshake is lost.
  assign grant         = (state == IDLE) && any_req && !f_full && ACLK_EN;
  assign out_P_ARREADY = grant ? (NUM_PORTS'(1) << win) : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      hold_addr <= '0;
      hold_len  <= '0;
`ifndef CDRAIN_READ_ARB_FIXED_PRIO_EN
      rr_ptr    <= IW'(NUM_PORTS-1);
`endif
    end else if (ACLK_EN) begin
      case (state)
        IDLE: if (grant) begin
          hold_addr <= in_P_ARADDR[win*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
          hold_len  <= in_P_ARLEN[win*32 +: 32];
`ifndef CDRAIN_READ_ARB_FIXED_PRIO_EN
          rr_ptr    <= win;
`endif
          state     <= BUSY;
        end
        BUSY: if (in_HLS_ARREADY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_HLS_ARVALID = (state == BUSY);
  assign out_HLS_ARADDR  = hold_addr;
  assign out_HLS_ARLEN   = hold_len;

  assign out_P_RDATA         = in_HLS_RDATA;
  assign out_P_RLAST         = in_HLS_RLAST;
  assign out_P_RVALID        = (!f_empty && in_HLS_RVALID) ? (NUM_PORTS'(1) << head) : '0;
  assign out_HLS_RREADY      = !f_empty && in_P_RREADY[head];
  assign out_HLS_RBUST_READY = !f_empty && in_P_RBURST_READY[head];
  assign pop                 = in_HLS_RVALID && out_HLS_RREADY && in_HLS_RLAST[0];

  c_drain_io_l3_out_serialize_c_m_axi_read_arb_ofifo #(
    .DEPTH(NUM_READ_OUTSTANDING),
    .W    (IW)
  ) u_ofifo (
    .clk  (ACLK),
    .rst  (ARESET),
    .en   (ACLK_EN),
    .push (grant),
    .pop  (pop),
    .din  (win),
    .dout (head),
    .empty(f_empty),
    .full (f_full)
  );

endmodule
